// File: rtl/sec_mem_responder.sv
// Domain-aware single-port memory responder with a 2-entry response FIFO.
// Low-domain accesses to the secure region are blocked, flagged and counted.
`timescale 1ns/1ps

module sec_mem_responder #(
  parameter int unsigned p_mem_nbytes   = 4096,
  parameter logic [31:0] p_secure_base  = 32'h800,
  parameter int unsigned p_opaque_nbits = 8
) (
  input  logic                      clk,
  input  logic                      reset,

  input  logic                      memreq_val,
  output logic                      memreq_rdy,
  input  logic                      memreq_domain,
  input  logic [2:0]                memreq_type,
  input  logic [p_opaque_nbits-1:0] memreq_opaque,
  input  logic [31:0]               memreq_addr,
  input  logic [1:0]                memreq_len,
  input  logic [31:0]               memreq_data,

  output logic                      memresp_val,
  input  logic                      memresp_rdy,
  output logic                      memresp_domain,
  output logic [2:0]                memresp_type,
  output logic [p_opaque_nbits-1:0] memresp_opaque,
  output logic [1:0]                memresp_len,
  output logic [31:0]               memresp_data,
  output logic                      memresp_err,

  output logic [15:0]               viol_count
);

  localparam int unsigned c_addr_bits = $clog2(p_mem_nbytes);
  localparam int unsigned c_idx_bits  = c_addr_bits - 2;
  localparam int unsigned c_nwords    = p_mem_nbytes / 4;

  typedef struct packed {
    logic                      domain;
    logic [2:0]                rtype;
    logic [p_opaque_nbits-1:0] opaque;
    logic [1:0]                len;
    logic [31:0]               data;
    logic                      err;
  } resp_t;

  logic [31:0]  r_mem [0:c_nwords-1];
  resp_t        r_buf [0:1];
  logic [1:0]   r_count;
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [15:0]  r_viol_count;

  logic [c_idx_bits-1:0] w_idx;
  logic [31:0]           w_idx_ext;
  logic                  w_blocked;
  logic                  w_is_write;
  logic                  w_enq;
  logic                  w_deq;
  logic                  w_val;
  logic [31:0]           w_rdata;
  resp_t                 w_new;
  resp_t                 w_head;
  logic [c_addr_bits-30:0] w_unused_addr;

  // Upper address bits wrap and byte offset is ignored: every access is a whole word.
  assign w_idx         = memreq_addr[c_addr_bits-1:2];
  assign w_idx_ext     = 32'(w_idx);
  assign w_unused_addr = {memreq_addr[31:c_addr_bits], memreq_addr[1:0]} == '0;

  assign w_blocked  = !memreq_domain && (w_idx_ext >= {2'b00, p_secure_base[31:2]});
  assign w_is_write = (memreq_type == 3'd1);

  assign memreq_rdy = (r_count < 2'd2);
  assign w_enq      = memreq_val && memreq_rdy && !reset;
  assign w_val      = (r_count != 2'd0);
  assign w_deq      = w_val && memresp_rdy;

  assign w_rdata = r_mem[w_idx];

  always_comb begin
    w_new        = '0;
    w_new.domain = memreq_domain;
    w_new.rtype  = memreq_type;
    w_new.opaque = memreq_opaque;
    w_new.len    = memreq_len;
    w_new.err    = w_blocked;
    w_new.data   = (w_blocked || w_is_write) ? 32'h0 : w_rdata;
  end

  always_ff @(posedge clk) begin
    if (w_enq && w_is_write && !w_blocked) begin
      r_mem[w_idx] <= memreq_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count      <= 2'd0;
      r_wr_ptr     <= 1'b0;
      r_rd_ptr     <= 1'b0;
      r_viol_count <= 16'h0;
      r_buf[0]     <= '0;
      r_buf[1]     <= '0;
    end else begin
      if (w_enq) begin
        r_buf[r_wr_ptr] <= w_new;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_deq) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
      if (w_enq && w_blocked && (r_viol_count != 16'hFFFF)) begin
        r_viol_count <= r_viol_count + 16'd1;
      end
    end
  end

  // Stale entries remain in the buffer after dequeue, so gate the head on valid.
  assign w_head = w_val ? r_buf[r_rd_ptr] : '0;

  assign memresp_val    = w_val;
  assign memresp_domain = w_head.domain;
  assign memresp_type   = w_head.rtype;
  assign memresp_opaque = w_head.opaque;
  assign memresp_len    = w_head.len;
  assign memresp_data   = w_head.data;
  assign memresp_err    = w_head.err;
  assign viol_count     = r_viol_count;

endmodule
